// File: rtl/arith_pkg.sv
// Shared encodings for the multi-cycle arithmetic unit: operation codes and FSM states.
package arith_pkg;

    typedef enum logic [1:0] {
        FUN_ADD = 2'd0,
        FUN_SUB = 2'd1,
        FUN_MUL = 2'd2,
        FUN_DIV = 2'd3
    } fun_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        SIGN = 2'd2
    } state_e;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock, WIDTH iterations after start.
// Optional macro ARITH_REM_EN exposes the final remainder as an output port.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient
`ifdef ARITH_REM_EN
    ,
    output logic [WIDTH-1:0] remainder
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dsr;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Bring the next dividend bit into the partial remainder and try subtracting the divisor.
    assign shifted = {rem, quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, dsr};

    // done marks the cycle whose closing edge performs the final iteration.
    assign done     = busy && (cnt == CNT_W'(1));
    assign quotient = quo;
`ifdef ARITH_REM_EN
    assign remainder = rem;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            busy <= 1'b0;
            cnt  <= '0;
            quo  <= '0;
            rem  <= '0;
            dsr  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= CNT_W'(WIDTH);
            quo  <= dividend;
            rem  <= '0;
            dsr  <= divisor;
        end else if (busy) begin
            quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
            rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            cnt <= cnt - CNT_W'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/arith_unit_mc.sv
// Multi-cycle signed arithmetic unit: single-cycle add/sub/mul, iterative signed divide.
// Optional macro ARITH_REM_EN adds the Rem_OUT port carrying the divide remainder.
module arith_unit_mc
    import arith_pkg::*;
#(
    parameter int IN_WIDTH        = 16,
    parameter int ARITH_OUT_WIDTH = 2 * IN_WIDTH
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [IN_WIDTH-1:0]        A,
    input  logic [IN_WIDTH-1:0]        B,
    input  logic                       Arith_EN,
    input  logic [1:0]                 ALU_FUN,
    output logic                       Arith_Ready,
    output logic [ARITH_OUT_WIDTH-1:0] Arith_OUT,
    output logic                       Carry_Out,
    output logic                       Ovf_Flag,
    output logic                       Div0_Err,
    output logic                       Arith_Flag
`ifdef ARITH_REM_EN
    ,
    output logic [IN_WIDTH-1:0]        Rem_OUT
`endif
);

    state_e state;
    state_e next;
    fun_e   fun;

    logic                         accept;
    logic                         div_start;
    logic                         div_busy;
    logic                         div_done;
    logic [IN_WIDTH-1:0]          a_mag;
    logic [IN_WIDTH-1:0]          b_mag;
    logic [IN_WIDTH-1:0]          quo_mag;
    logic                         neg_q;
    logic [IN_WIDTH:0]            q_ext;
    logic signed [IN_WIDTH:0]     q_s;
    logic signed [IN_WIDTH:0]     sum_s;
    logic signed [IN_WIDTH:0]     diff_s;
    logic [IN_WIDTH:0]            usum;
    logic [IN_WIDTH:0]            udiff;
    logic signed [2*IN_WIDTH-1:0] prod;
`ifdef ARITH_REM_EN
    logic                         neg_r;
    logic [IN_WIDTH-1:0]          rem_mag;
    logic signed [IN_WIDTH-1:0]   r_s;
`endif

    assign fun       = fun_e'(ALU_FUN);
    assign accept    = Arith_EN && (state == IDLE);
    assign div_start = accept && (fun == FUN_DIV) && (B != '0);

    // Exact one-bit-wider sums keep the true signed value; unsigned copies give carry/borrow.
    assign sum_s  = {A[IN_WIDTH-1], A} + {B[IN_WIDTH-1], B};
    assign diff_s = {A[IN_WIDTH-1], A} - {B[IN_WIDTH-1], B};
    assign usum   = {1'b0, A} + {1'b0, B};
    assign udiff  = {1'b0, A} - {1'b0, B};
    assign prod   = $signed(A) * $signed(B);

    // Magnitude of MIN is 2^(IN_WIDTH-1), which still fits as an unsigned IN_WIDTH value.
    assign a_mag = A[IN_WIDTH-1] ? -A : A;
    assign b_mag = B[IN_WIDTH-1] ? -B : B;

    assign q_ext = {1'b0, quo_mag};
    assign q_s   = neg_q ? -q_ext : q_ext;

    seq_divider #(
        .WIDTH(IN_WIDTH)
    ) u_div (
        .CLK      (CLK),
        .RST      (RST),
        .start    (div_start),
        .dividend (a_mag),
        .divisor  (b_mag),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quo_mag)
`ifdef ARITH_REM_EN
        ,
        .remainder(rem_mag)
`endif
    );

`ifdef ARITH_REM_EN
    assign r_s = neg_r ? -rem_mag : rem_mag;
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    // NOTE: defaults first so every path assigns next/Arith_Ready and no latch is inferred.
    always_comb begin
        next        = state;
        Arith_Ready = 1'b0;
        case (state)
            IDLE: begin
                Arith_Ready = 1'b1;
                if (div_start) begin
                    next = DIV;
                end
            end
            DIV: begin
                if (div_done) begin
                    next = SIGN;
                end else if (!div_busy) begin
                    next = IDLE;
                end
            end
            SIGN:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            Arith_OUT  <= '0;
            Carry_Out  <= 1'b0;
            Ovf_Flag   <= 1'b0;
            Div0_Err   <= 1'b0;
            Arith_Flag <= 1'b0;
            neg_q      <= 1'b0;
`ifdef ARITH_REM_EN
            neg_r      <= 1'b0;
            Rem_OUT    <= '0;
`endif
        end else begin
            Arith_Flag <= 1'b0;
            if (accept) begin
                // Capture the result signs now; operands may change while the divider runs.
                neg_q <= A[IN_WIDTH-1] ^ B[IN_WIDTH-1];
`ifdef ARITH_REM_EN
                neg_r <= A[IN_WIDTH-1];
`endif
                if (!div_start) begin
                    Arith_Flag <= 1'b1;
                    Carry_Out  <= 1'b0;
                    Ovf_Flag   <= 1'b0;
                    Div0_Err   <= 1'b0;
                    Arith_OUT  <= '0;
`ifdef ARITH_REM_EN
                    Rem_OUT    <= '0;
`endif
                    case (fun)
                        FUN_ADD: begin
                            Arith_OUT <= ARITH_OUT_WIDTH'(sum_s);
                            Carry_Out <= usum[IN_WIDTH];
                            Ovf_Flag  <= sum_s[IN_WIDTH] ^ sum_s[IN_WIDTH-1];
                        end
                        FUN_SUB: begin
                            Arith_OUT <= ARITH_OUT_WIDTH'(diff_s);
                            Carry_Out <= ~udiff[IN_WIDTH];
                            Ovf_Flag  <= diff_s[IN_WIDTH] ^ diff_s[IN_WIDTH-1];
                        end
                        FUN_MUL: Arith_OUT <= ARITH_OUT_WIDTH'(prod);
                        default: Div0_Err  <= 1'b1;
                    endcase
                end
            end else if (state == SIGN) begin
                Arith_Flag <= 1'b1;
                Arith_OUT  <= ARITH_OUT_WIDTH'(q_s);
                Carry_Out  <= 1'b0;
                Ovf_Flag   <= 1'b0;
                Div0_Err   <= 1'b0;
`ifdef ARITH_REM_EN
                Rem_OUT    <= r_s;
`endif
            end
        end
    end

endmodule

// File: tb/tb_arith_unit_mc.sv
// Randomised self-checking bench for arith_unit_mc against an integer-arithmetic reference model.
module tb_arith_unit_mc;

    localparam int W  = 16;
    localparam int OW = 32;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic          Arith_EN = 1'b0;
    logic [1:0]    ALU_FUN = 2'd0;
    logic          Arith_Ready;
    logic [OW-1:0] Arith_OUT;
    logic          Carry_Out;
    logic          Ovf_Flag;
    logic          Div0_Err;
    logic          Arith_Flag;
`ifdef ARITH_REM_EN
    logic [W-1:0]  Rem_OUT;
`endif

    int total = 0;
    int bad   = 0;

    arith_unit_mc #(.IN_WIDTH(W), .ARITH_OUT_WIDTH(OW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .A          (A),
        .B          (B),
        .Arith_EN   (Arith_EN),
        .ALU_FUN    (ALU_FUN),
        .Arith_Ready(Arith_Ready),
        .Arith_OUT  (Arith_OUT),
        .Carry_Out  (Carry_Out),
        .Ovf_Flag   (Ovf_Flag),
        .Div0_Err   (Div0_Err),
        .Arith_Flag (Arith_Flag)
`ifdef ARITH_REM_EN
        ,
        .Rem_OUT    (Rem_OUT)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [OW-1:0] out;
        logic          carry;
        logic          ovf;
        logic          div0;
        logic [W-1:0]  rem;
        int            lat;
    } exp_t;

    // Reference results from plain signed/unsigned integer arithmetic.
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sb, ua, ub, r, m;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        e.out = '0; e.carry = 1'b0; e.ovf = 1'b0; e.div0 = 1'b0; e.rem = '0; e.lat = 0;
        case (op)
            2'd0: begin
                r = sa + sb;
                e.out = r[OW-1:0];
                e.carry = (ua + ub) > 65535;
                e.ovf = (r > 32767) || (r < -32768);
            end
            2'd1: begin
                r = sa - sb;
                e.out = r[OW-1:0];
                e.carry = (ua >= ub);
                e.ovf = (r > 32767) || (r < -32768);
            end
            2'd2: begin
                r = sa * sb;
                e.out = r[OW-1:0];
            end
            default: begin
                if (sb == 0) begin
                    e.div0 = 1'b1;
                end else begin
                    r = sa / sb;
                    m = sa % sb;
                    e.out = r[OW-1:0];
                    e.rem = m[W-1:0];
                    e.lat = W + 1;
                end
            end
        endcase
        return e;
    endfunction

    // Issue one op and wait (bounded) for the completion pulse.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int edges, output int busy);
        @(negedge CLK);
        A = a; B = b; ALU_FUN = op; Arith_EN = 1'b1;
        @(posedge CLK);
        #1;
        Arith_EN = 1'b0;
        edges = 0;
        busy  = 0;
        while (!Arith_Flag && edges < 40) begin
            if (!Arith_Ready) busy++;
            @(posedge CLK);
            #1;
            edges++;
        end
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] corners [5];
        corners[0] = 16'h8000; corners[1] = 16'hFFFF; corners[2] = 16'h0000;
        corners[3] = 16'h7FFF; corners[4] = 16'h0001;
        if ($urandom_range(3) == 0) return corners[$urandom_range(4)];
        return W'($urandom);
    endfunction

    task automatic test_reset();
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        total++; if (Arith_OUT !== '0) begin bad++; $display("FAIL reset_out got=%h want=0", Arith_OUT); end
        total++; if (Carry_Out !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b want=0", Carry_Out); end
        total++; if (Ovf_Flag !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", Ovf_Flag); end
        total++; if (Div0_Err !== 1'b0) begin bad++; $display("FAIL reset_div0 got=%b want=0", Div0_Err); end
        total++; if (Arith_Flag !== 1'b0) begin bad++; $display("FAIL reset_flag got=%b want=0", Arith_Flag); end
        total++; if (Arith_Ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", Arith_Ready); end
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_directed();
        logic [1:0]    ops  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic [W-1:0]  as   [6] = '{16'h7FFF, 16'd3, 16'hFFFD, 16'hFFF9, 16'h8000, 16'd5};
        logic [W-1:0]  bs   [6] = '{16'h0001, 16'd5, 16'd7, 16'd2, 16'hFFFF, 16'd0};
        logic [OW-1:0] outs [6] = '{32'h0000_8000, 32'hFFFF_FFFE, 32'hFFFF_FFEB,
                                    32'hFFFF_FFFD, 32'h0000_8000, 32'h0000_0000};
        exp_t e;
        int   edges, busy;
        for (int i = 0; i < 6; i++) begin
            e = model(ops[i], as[i], bs[i]);
            run_op(ops[i], as[i], bs[i], edges, busy);
            total++; if (Arith_OUT !== outs[i]) begin bad++; $display("FAIL dir_out[%0d] got=%h want=%h", i, Arith_OUT, outs[i]); end
            total++; if (Carry_Out !== e.carry) begin bad++; $display("FAIL dir_carry[%0d] got=%b want=%b", i, Carry_Out, e.carry); end
            total++; if (Ovf_Flag !== e.ovf) begin bad++; $display("FAIL dir_ovf[%0d] got=%b want=%b", i, Ovf_Flag, e.ovf); end
            total++; if (Div0_Err !== e.div0) begin bad++; $display("FAIL dir_div0[%0d] got=%b want=%b", i, Div0_Err, e.div0); end
            total++; if (edges !== e.lat) begin bad++; $display("FAIL dir_lat[%0d] got=%0d want=%0d", i, edges, e.lat); end
            total++; if (busy !== e.lat) begin bad++; $display("FAIL dir_busy[%0d] got=%0d want=%0d", i, busy, e.lat); end
`ifdef ARITH_REM_EN
            total++; if (Rem_OUT !== e.rem) begin bad++; $display("FAIL dir_rem[%0d] got=%h want=%h", i, Rem_OUT, e.rem); end
`endif
            @(posedge CLK);
            #1;
            total++; if (Arith_Flag !== 1'b0) begin bad++; $display("FAIL dir_pulse[%0d] got=%b want=0", i, Arith_Flag); end
            total++; if (Arith_OUT !== outs[i]) begin bad++; $display("FAIL dir_hold[%0d] got=%h want=%h", i, Arith_OUT, outs[i]); end
        end
    endtask

    task automatic test_random();
        exp_t         e;
        int           edges, busy;
        logic [1:0]   op;
        logic [W-1:0] a, b;
        for (int i = 0; i < 200; i++) begin
            op = 2'($urandom_range(3));
            a  = pick();
            b  = pick();
            e  = model(op, a, b);
            run_op(op, a, b, edges, busy);
            total++; if (Arith_OUT !== e.out) begin bad++; $display("FAIL rnd_out op=%0d a=%h b=%h got=%h want=%h", op, a, b, Arith_OUT, e.out); end
            total++; if (Carry_Out !== e.carry) begin bad++; $display("FAIL rnd_carry op=%0d a=%h b=%h got=%b want=%b", op, a, b, Carry_Out, e.carry); end
            total++; if (Ovf_Flag !== e.ovf) begin bad++; $display("FAIL rnd_ovf op=%0d a=%h b=%h got=%b want=%b", op, a, b, Ovf_Flag, e.ovf); end
            total++; if (Div0_Err !== e.div0) begin bad++; $display("FAIL rnd_div0 op=%0d a=%h b=%h got=%b want=%b", op, a, b, Div0_Err, e.div0); end
            total++; if (edges !== e.lat) begin bad++; $display("FAIL rnd_lat op=%0d a=%h b=%h got=%0d want=%0d", op, a, b, edges, e.lat); end
`ifdef ARITH_REM_EN
            total++; if (Rem_OUT !== e.rem) begin bad++; $display("FAIL rnd_rem op=%0d a=%h b=%h got=%h want=%h", op, a, b, Rem_OUT, e.rem); end
`endif
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   edges, busy;
        e = model(2'd3, 16'hFF9C, 16'd7);
        @(negedge CLK);
        A = 16'hFF9C; B = 16'd7; ALU_FUN = 2'd3; Arith_EN = 1'b1;
        @(posedge CLK);
        #1;
        Arith_EN = 1'b0;
        edges = 0;
        repeat (5) begin @(posedge CLK); #1; edges++; end
        @(negedge CLK);
        A = 16'd1; B = 16'd1; ALU_FUN = 2'd0; Arith_EN = 1'b1;
        @(posedge CLK);
        #1;
        edges++;
        Arith_EN = 1'b0;
        while (!Arith_Flag && edges < 40) begin @(posedge CLK); #1; edges++; end
        total++; if (edges !== W + 1) begin bad++; $display("FAIL b2b_div_lat got=%0d want=%0d", edges, W + 1); end
        total++; if (Arith_OUT !== e.out) begin bad++; $display("FAIL b2b_div_out got=%h want=%h", Arith_OUT, e.out); end
        total++; if (Arith_Ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", Arith_Ready); end
        run_op(2'd0, 16'h1234, 16'h0101, edges, busy);
        total++; if (edges !== 0) begin bad++; $display("FAIL b2b_add_lat got=%0d want=0", edges); end
        total++; if (Arith_OUT !== 32'h0000_1335) begin bad++; $display("FAIL b2b_add_out got=%h want=00001335", Arith_OUT); end
        @(posedge CLK);
        #1;
        total++; if (Arith_Flag !== 1'b0) begin bad++; $display("FAIL b2b_extra_flag got=%b want=0", Arith_Flag); end
    endtask

    task automatic test_reset_mid_div();
        int edges, busy, seen;
        run_op(2'd1, 16'd5, 16'd3, edges, busy);
        @(negedge CLK);
        A = 16'd1000; B = 16'd3; ALU_FUN = 2'd3; Arith_EN = 1'b1;
        @(posedge CLK);
        #1;
        Arith_EN = 1'b0;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        total++; if (Arith_OUT !== '0) begin bad++; $display("FAIL rst_mid_out got=%h want=0", Arith_OUT); end
        total++; if (Carry_Out !== 1'b0) begin bad++; $display("FAIL rst_mid_carry got=%b want=0", Carry_Out); end
        total++; if (Arith_Ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b want=1", Arith_Ready); end
        total++; if (Arith_Flag !== 1'b0) begin bad++; $display("FAIL rst_mid_flag got=%b want=0", Arith_Flag); end
        RST = 1'b1;
        run_op(2'd0, 16'd2, 16'd2, edges, busy);
        total++; if (edges !== 0) begin bad++; $display("FAIL rst_add_lat got=%0d want=0", edges); end
        total++; if (Arith_OUT !== 32'd4) begin bad++; $display("FAIL rst_add_out got=%h want=4", Arith_OUT); end
        seen = 0;
        repeat (20) begin @(posedge CLK); #1; if (Arith_Flag) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL rst_stale_flags got=%0d want=0", seen); end
        total++; if (Arith_OUT !== 32'd4) begin bad++; $display("FAIL rst_add_hold got=%h want=4", Arith_OUT); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
